mdu_seq: RTL and testbench
==========================

# mdu_seq

Parametrised, multi-cycle multiply/divide unit for the pipelined MIPS core's EX stage. It owns the HI/LO registers and executes mult/multu/div/divu with configurable latencies, as well as mthi/mtlo writes and mfhi/mflo reads. It exports a busy flag that the hazard unit uses to stall md/mt/mf instructions. It adds what the previous unit lacked: width generality, defined divide-by-zero and overflow results, and a cancel input for the upcoming exception-flush path.

## Interface
Parameters:
- WIDTH, 32, operand width and HI/LO width.
- MULT_LAT, 5, cycles busy stays high for mult/multu; must be ≥1.
- DIV_LAT, 10, cycles busy stays high for div/divu; must be ≥1.

Ports:
- clk  in  1  Single clock.
- reset  in  1  Asynchronous, active-low reset.
- start  in  1  Launch the op on `op` this cycle; must be asserted only for md ops.
- op  in  3  MDUOp: 0 mult, 1 multu, 2 div, 3 divu, 4 mtlo, 5 mthi, 6 mflo, 7 mfhi.
- we  in  1  Qualifies mtlo/mthi writes.
- cancel  in  1  Abort an in-flight op (exception flush).
- a  in  WIDTH  rs value (dividend, multiplicand, or mt data).
- b  in  WIDTH  rt value (divisor or multiplier).
- busy  out  1  High while an md op is in flight.
- result  out  WIDTH  mflo → lo, mfhi → hi, any other op → 0.
- hi, lo  out  WIDTH  Architectural HI/LO registers.

## Operation
- States:
  - IDLE → BUSY on start & op∈{0..3} & !cancel.
  - BUSY → IDLE when the counter reaches its terminal count, or when cancel is asserted.
- Launch latches op, a, b and loads the down-counter with MULT_LAT or DIV_LAT.
- mult/multu: {hi,lo} ← 2·WIDTH-bit signed/unsigned product.
- div: quotient truncates toward zero; remainder takes the sign of the dividend.
- div overflow (−2^(WIDTH−1) / −1): lo = −2^(WIDTH−1), hi = 0.
- divu, and div by zero: lo = all ones, hi = dividend.
- Commit: hi and lo are written only on the final BUSY cycle's edge. Until then, the old values stay visible.
- mtlo/mthi: with we=1 in IDLE, lo/hi ← a at the clock edge. An mt issued while busy=1 is ignored (the hazard unit guarantees this does not occur).
- start during BUSY is ignored; the in-flight op is unaffected.
- cancel in BUSY: return to IDLE next cycle; hi/lo are unchanged; partial results are discarded.
- cancel in IDLE with start: the launch is suppressed. cancel in IDLE with mt: the write is suppressed.
- result is combinational from the hi/lo registers and op; no bypass from an in-flight op.

## Timing
- Reset (async, active-low): hi = lo = 0, busy = 0, state IDLE, counter = 0; result = 0 unless op selects mf.
- Launch at edge t (start sampled high):
  - busy = 1 during cycles t+1 … t+LAT.
  - hi/lo hold new values from cycle t+LAT+1.
  - busy = 0 in cycle t+LAT+1.
- The hazard unit stalls on (start | busy). busy therefore need not be combinationally high in the start cycle itself.
- The earliest back-to-back launch is cycle t+LAT+1.
- mt write latency: 1 edge. result latency: 0 (combinational).
- Reset asserted mid-op: immediate return to reset values; no commit.

## Structure
- Shared def package/header: MDUOp codes 0–7 (MDU_mult … MDU_mfhi, same names as the existing controller defines) and the state encodings.
- Sub-module `mdu_arith`: combinational; takes op, a, b, WIDTH and produces {hi_next, lo_next}, including the divide-by-zero and overflow rules.
- `mdu_seq` holds the FSM, the latency counter, the operand/op latches, and HI/LO.

## Test plan
- mult, a = −3, b = 5, MULT_LAT = 5 → busy high for 5 cycles; then hi = 0xFFFFFFFF, lo = 0xFFFFFFF1; hi/lo unchanged while busy.
- multu, a = 0xFFFFFFFF, b = 2 → hi = 0x00000001, lo = 0xFFFFFFFE.
- div −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF after DIV_LAT = 10 busy cycles.
- div 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- divu 9 / 0 → lo = 0xFFFFFFFF, hi = 9.
- mthi 0x1234 then mfhi → result = 0x1234 the next cycle.
- div launched, then cancel asserted at busy cycle 3 → busy = 0 next cycle; prior hi/lo retained.
- start asserted again mid-op → ignored; hi/lo reflect only the first op.
- Async reset pulse mid-mult → hi = lo = 0 and busy = 0 immediately.
- Re-run all scenarios with WIDTH = 16, MULT_LAT = 1, DIV_LAT = 1.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - MDUOp codes (same names as the core's controller defines)
//   - FSM state encodings for mdu_seq
//   - mdu_is_md(): true for the four multi-cycle ops (mult/multu/div/divu)
package mdu_seq_pkg;

    typedef enum logic [2:0] {
        MDU_mult  = 3'd0,
        MDU_multu = 3'd1,
        MDU_div   = 3'd2,
        MDU_divu  = 3'd3,
        MDU_mtlo  = 3'd4,
        MDU_mthi  = 3'd5,
        MDU_mflo  = 3'd6,
        MDU_mfhi  = 3'd7
    } mdu_op_e;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Codes 0..3 are exactly the ones with bit 2 clear.
    function automatic logic mdu_is_md(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/mdu_seq_arith.sv
// Combinational arithmetic core of the multiply/divide unit.
// Produces the HI/LO values an op would commit, including the defined
// divide-by-zero (lo = all ones, hi = dividend) and signed-overflow
// (lo = -2^(WIDTH-1), hi = 0) results.
// Ports:
//   i_op       MDUOp code (only 0..3 produce non-zero results)
//   i_a, i_b   rs / rt operands
//   o_hi_next  value for HI
//   o_lo_next  value for LO
module mdu_arith
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi_next,
    output logic [WIDTH-1:0] o_lo_next
);

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic signed [2*WIDTH-1:0] w_prod_s;
    logic        [2*WIDTH-1:0] w_prod_u;
    logic                      w_div_zero;
    logic                      w_div_ovf;
    logic        [WIDTH-1:0]   w_b_safe;
    logic signed [WIDTH-1:0]   w_quot_s;
    logic signed [WIDTH-1:0]   w_rem_s;
    logic        [WIDTH-1:0]   w_quot_u;
    logic        [WIDTH-1:0]   w_rem_u;

    assign w_prod_s = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) *
                      $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});
    assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

    assign w_div_zero = (i_b == '0);
    assign w_div_ovf  = (i_a == MIN_NEG) && (i_b == ALL_ONES);

    // The special cases are overridden below; substituting 1 keeps the
    // dividers away from the undefined / overflowing operand pairs.
    assign w_b_safe = (w_div_zero || w_div_ovf) ? ONE : i_b;

    // SystemVerilog signed / and % truncate toward zero, remainder takes
    // the dividend's sign.
    assign w_quot_s = $signed(i_a) / $signed(w_b_safe);
    assign w_rem_s  = $signed(i_a) % $signed(w_b_safe);
    assign w_quot_u = i_a / w_b_safe;
    assign w_rem_u  = i_a % w_b_safe;

    always_comb begin
        o_hi_next = '0;
        o_lo_next = '0;
        case (i_op)
            MDU_mult:  {o_hi_next, o_lo_next} = w_prod_s;
            MDU_multu: {o_hi_next, o_lo_next} = w_prod_u;
            MDU_div: begin
                if (w_div_zero) begin
                    o_lo_next = ALL_ONES;
                    o_hi_next = i_a;
                end else if (w_div_ovf) begin
                    o_lo_next = MIN_NEG;
                    o_hi_next = '0;
                end else begin
                    o_lo_next = w_quot_s;
                    o_hi_next = w_rem_s;
                end
            end
            MDU_divu: begin
                if (w_div_zero) begin
                    o_lo_next = ALL_ONES;
                    o_hi_next = i_a;
                end else begin
                    o_lo_next = w_quot_u;
                    o_hi_next = w_rem_u;
                end
            end
            default: begin
                o_hi_next = '0;
                o_lo_next = '0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit for the EX stage. Owns HI/LO, runs
// mult/multu/div/divu with fixed latencies, handles mthi/mtlo writes and
// mfhi/mflo reads, and exports busy for the hazard unit.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no md op in flight; mt writes accepted, launches accepted
// BUSY    | md op in flight; counter runs down, commit on count 1
//
// Ports:
//   clk, reset        clock, async active-low reset
//   start, op         launch request and MDUOp code
//   we                qualifies mtlo/mthi
//   cancel            abort in-flight op / suppress launch and mt
//   a, b              rs / rt operands
//   busy              md op in flight
//   result            lo for mflo, hi for mfhi, else 0
//   hi, lo            architectural HI/LO
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,     // >= 1
    parameter int DIV_LAT  = 10     // >= 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             we,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_launch;
    logic             w_done;
    logic             w_mt;
    logic             w_is_div;
    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;

    assign w_is_div = (op == MDU_div) || (op == MDU_divu);
    assign w_launch = (r_state == ST_IDLE) && start && mdu_is_md(op) && !cancel;
    // Counter value 1 marks the final busy cycle; cancel on that same
    // cycle still discards the result.
    assign w_done   = (r_state == ST_BUSY) && !cancel && (r_cnt == CNT_LAST);
    assign w_mt     = (r_state == ST_IDLE) && we && !cancel &&
                      ((op == MDU_mtlo) || (op == MDU_mthi));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= w_is_div ? DIV_LOAD : MULT_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (cancel || (r_cnt == CNT_LAST)) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt - CNT_LAST;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op <= '0;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_launch) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
        end
    end

    mdu_arith #(
        .WIDTH(WIDTH)
    ) u_arith (
        .i_op      (r_op),
        .i_a       (r_a),
        .i_b       (r_b),
        .o_hi_next (w_hi_next),
        .o_lo_next (w_lo_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            r_hi <= w_hi_next;
            r_lo <= w_lo_next;
        end else if (w_mt) begin
            if (op == MDU_mtlo) begin
                r_lo <= a;
            end else begin
                r_hi <= a;
            end
        end
    end

    // No bypass: reads see the architectural registers only.
    always_comb begin
        result = '0;
        if (op == MDU_mflo) begin
            result = r_lo;
        end else if (op == MDU_mfhi) begin
            result = r_hi;
        end
    end

    assign busy = (r_state == ST_BUSY);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          len;
    } commit_t;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
    } read_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn  [2];
    logic        st    [2];
    logic [2:0]  opv   [2];
    logic        wev   [2];
    logic        cnv   [2];
    logic [31:0] av    [2];
    logic [31:0] bv    [2];
    logic        rd_chk[2];

    logic        d0_busy, d1_busy;
    logic [31:0] d0_res, d0_hi, d0_lo;
    logic [15:0] d1_res, d1_hi, d1_lo;

    commit_t     cq [2][$];
    read_t       rq [2][$];
    logic [31:0] m_hi [2];
    logic [31:0] m_lo [2];
    int          wd   [2];
    int          mlat [2];
    int          dlat [2];
    int          bcnt [2];
    logic        pbusy[2];

    int checks = 0;
    int errors = 0;

    mdu_seq #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) u_dut0 (
        .clk(clk), .reset(rstn[0]), .start(st[0]), .op(opv[0]), .we(wev[0]),
        .cancel(cnv[0]), .a(av[0]), .b(bv[0]),
        .busy(d0_busy), .result(d0_res), .hi(d0_hi), .lo(d0_lo));

    mdu_seq #(.WIDTH(16), .MULT_LAT(1), .DIV_LAT(1)) u_dut1 (
        .clk(clk), .reset(rstn[1]), .start(st[1]), .op(opv[1]), .we(wev[1]),
        .cancel(cnv[1]), .a(av[1][15:0]), .b(bv[1][15:0]),
        .busy(d1_busy), .result(d1_res), .hi(d1_hi), .lo(d1_lo));

    task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL d%0d %s: got %h expected %h", d, nm, act, exp);
        end
    endtask

    task automatic fail_evt(input int d, input string nm);
        checks++;
        errors++;
        $display("FAIL d%0d %s: got unexpected event expected none", d, nm);
    endtask

    function automatic logic [31:0] msk(input int d);
        return (wd[d] == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    // Reference: plain integer arithmetic on the architectural definition.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input int w);
        longint unsigned m, ua, ub, hv, lv;
        longint sa, sb, p, q, r, minv;
        m    = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & m;
        ub   = {32'd0, b} & m;
        sa   = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb   = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        minv = -(longint'(1) << (w - 1));
        hv = 0;
        lv = 0;
        case (op)
            3'd0: begin p = sa * sb; hv = (p >>> w) & m; lv = p & m; end
            3'd1: begin hv = ((ua * ub) >> w) & m; lv = (ua * ub) & m; end
            3'd2: begin
                if (sb == 0) begin lv = m; hv = ua; end
                else if (sa == minv && sb == -1) begin lv = ua; hv = 0; end
                else begin q = sa / sb; r = sa % sb; lv = q & m; hv = r & m; end
            end
            3'd3: begin
                if (ub == 0) begin lv = m; hv = ua; end
                else begin lv = ua / ub; hv = ua % ub; end
            end
            default: begin hv = 0; lv = 0; end
        endcase
        return {hv[31:0], lv[31:0]};
    endfunction

    task automatic mon(input int d, input logic bz, input logic [31:0] res,
                       input logic [31:0] hv, input logic [31:0] lv);
        commit_t e;
        read_t   r;
        if (bz) begin
            bcnt[d]++;
            if (cq[d].size() == 0) fail_evt(d, "unexpected_busy");
            else begin
                chk(d, "hold_hi", hv, cq[d][0].old_hi);
                chk(d, "hold_lo", lv, cq[d][0].old_lo);
            end
        end
        if (pbusy[d] && !bz) begin
            if (cq[d].size() == 0) fail_evt(d, "unexpected_busy_end");
            else begin
                e = cq[d].pop_front();
                chk(d, "commit_hi", hv, e.hi);
                chk(d, "commit_lo", lv, e.lo);
                if (e.len >= 0) chk(d, "busy_len", bcnt[d], e.len);
            end
        end
        if (!bz) bcnt[d] = 0;
        pbusy[d] = bz;
        if (rd_chk[d]) begin
            if (rq[d].size() == 0) fail_evt(d, "read_no_expect");
            else begin
                r = rq[d].pop_front();
                chk(d, "result", res, r.res);
                chk(d, "rd_hi", hv, r.hi);
                chk(d, "rd_lo", lv, r.lo);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, d0_busy, d0_res, d0_hi, d0_lo);
        mon(1, d1_busy, {16'h0, d1_res}, {16'h0, d1_hi}, {16'h0, d1_lo});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int d, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int len, input logic commit);
        commit_t     e;
        logic [63:0] res;
        res      = ref_md(op, a & msk(d), b & msk(d), wd[d]);
        e.old_hi = m_hi[d];
        e.old_lo = m_lo[d];
        e.hi     = commit ? res[63:32] : m_hi[d];
        e.lo     = commit ? res[31:0]  : m_lo[d];
        e.len    = len;
        cq[d].push_back(e);
        if (commit) begin
            m_hi[d] = res[63:32];
            m_lo[d] = res[31:0];
        end
        st[d]  = 1'b1;
        opv[d] = op;
        av[d]  = a & msk(d);
        bv[d]  = b & msk(d);
        step();
        st[d]  = 1'b0;
    endtask

    function automatic int lat_of(input int d, input logic [2:0] op);
        return op[1] ? dlat[d] : mlat[d];
    endfunction

    task automatic md(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        launch(d, op, a, b, lat_of(d, op), 1'b1);
        repeat (lat_of(d, op)) step();
    endtask

    task automatic rd(input int d, input logic [2:0] op);
        read_t r;
        r.res = (op == MDU_mflo) ? m_lo[d] : (op == MDU_mfhi) ? m_hi[d] : 32'h0;
        r.hi  = m_hi[d];
        r.lo  = m_lo[d];
        rq[d].push_back(r);
        opv[d]    = op;
        rd_chk[d] = 1'b1;
        step();
        rd_chk[d] = 1'b0;
    endtask

    task automatic mt(input int d, input logic [2:0] op, input logic [31:0] val, input logic c);
        opv[d] = op;
        wev[d] = 1'b1;
        cnv[d] = c;
        av[d]  = val & msk(d);
        if (!c) begin
            if (op == MDU_mtlo) m_lo[d] = val & msk(d);
            else                m_hi[d] = val & msk(d);
        end
        step();
        wev[d] = 1'b0;
        cnv[d] = 1'b0;
    endtask

    task automatic run(input int d);
        int          k;
        logic [31:0] m, ra, rb, minv;
        logic [2:0]  rop;
        m    = msk(d);
        minv = (wd[d] == 32) ? 32'h8000_0000 : 32'h0000_8000;

        chk(d, "busy_after_reset", {31'd0, (d == 0) ? d0_busy : d1_busy}, 32'd0);
        rd(d, MDU_mflo);
        rd(d, MDU_mfhi);
        rd(d, MDU_mult);

        md(d, MDU_mult, 32'hFFFF_FFFD, 32'd5);
        md(d, MDU_multu, 32'hFFFF_FFFF, 32'd2);
        md(d, MDU_div, 32'hFFFF_FFF9, 32'd2);
        md(d, MDU_div, minv, 32'hFFFF_FFFF);
        md(d, MDU_divu, 32'd9, 32'd0);
        md(d, MDU_div, 32'hFFFF_FFFB, 32'd0);
        rd(d, MDU_mflo);

        mt(d, MDU_mthi, 32'h1234, 1'b0);
        rd(d, MDU_mfhi);
        mt(d, MDU_mtlo, 32'h5678, 1'b0);
        rd(d, MDU_mflo);
        mt(d, MDU_mtlo, 32'hABCD, 1'b1);
        rd(d, MDU_mflo);

        // cancel at busy cycle k
        k = (dlat[d] < 3) ? dlat[d] : 3;
        launch(d, MDU_div, 32'd100, 32'd7, k, 1'b0);
        repeat (k - 1) step();
        cnv[d] = 1'b1;
        step();
        cnv[d] = 1'b0;
        rd(d, MDU_mflo);
        rd(d, MDU_mfhi);

        // second start inside the busy window
        k = (mlat[d] < 2) ? mlat[d] : 2;
        launch(d, MDU_mult, 32'd6, 32'd7, mlat[d], 1'b1);
        repeat (k - 1) step();
        st[d] = 1'b1; opv[d] = MDU_div; av[d] = 32'd50; bv[d] = 32'd5;
        step();
        st[d] = 1'b0;
        repeat (mlat[d] - k) step();
        rd(d, MDU_mflo);

        // launch suppressed by cancel in IDLE
        st[d] = 1'b1; opv[d] = MDU_mult; av[d] = 32'd3; bv[d] = 32'd3; cnv[d] = 1'b1;
        step();
        st[d] = 1'b0; cnv[d] = 1'b0;
        step();
        rd(d, MDU_mflo);

        // async reset while a mult is in flight
        launch(d, MDU_mult, 32'd11, 32'd13, -1, 1'b1);
        @(negedge clk);
        #1;
        cq[d][0].hi = 32'h0;
        cq[d][0].lo = 32'h0;
        m_hi[d] = 32'h0;
        m_lo[d] = 32'h0;
        rstn[d] = 1'b0;
        #1;
        if (d == 0) begin
            chk(d, "rst_busy", {31'd0, d0_busy}, 32'd0);
            chk(d, "rst_hi", d0_hi, 32'd0);
            chk(d, "rst_lo", d0_lo, 32'd0);
        end else begin
            chk(d, "rst_busy", {31'd0, d1_busy}, 32'd0);
            chk(d, "rst_hi", {16'h0, d1_hi}, 32'd0);
            chk(d, "rst_lo", {16'h0, d1_lo}, 32'd0);
        end
        step();
        step();
        rstn[d] = 1'b1;
        step();
        rd(d, MDU_mfhi);

        for (int i = 0; i < 30; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? minv : ($urandom() & m);
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = m;
                default: rb = $urandom() & m;
            endcase
            case ($urandom_range(0, 5))
                4: begin
                    rop = $urandom_range(0, 1) ? MDU_mthi : MDU_mtlo;
                    mt(d, rop, ra, 1'b0);
                end
                5: begin
                    rop = $urandom_range(0, 1) ? MDU_mfhi : MDU_mflo;
                    rd(d, rop);
                end
                default: begin
                    rop = 3'($urandom_range(0, 3));
                    md(d, rop, ra, rb);
                end
            endcase
        end
        rd(d, MDU_mflo);
        rd(d, MDU_mfhi);
    endtask

    initial begin
        wd   = '{32, 16};
        mlat = '{5, 1};
        dlat = '{10, 1};
        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0; st[d] = 1'b0; opv[d] = 3'd0; wev[d] = 1'b0;
            cnv[d] = 1'b0; av[d] = 32'd0; bv[d] = 32'd0; rd_chk[d] = 1'b0;
            m_hi[d] = 32'd0; m_lo[d] = 32'd0; bcnt[d] = 0; pbusy[d] = 1'b0;
        end
        step();
        step();
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
        step();

        run(0);
        run(1);
        repeat (4) step();

        for (int d = 0; d < 2; d++) begin
            chk(d, "commit_queue_left", cq[d].size(), 32'd0);
            chk(d, "read_queue_left", rq[d].size(), 32'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
